uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO.
// The frame format is set by parameters (data bits, parity, stop bits).
// Queued characters are sent back to back, with no idle gap between frames.
// Ports:
//   clk      - system clock; all state changes on its rising edge
//   rst_n    - synchronous active-low reset
//   d        - character to queue
//   strobe   - write enable; d is pushed when strobe=1 and full=0
//   tx       - serial line, idle high (registered)
//   busy     - FIFO non-empty or a frame on the line (registered)
//   full     - FIFO holds FIFO_DEPTH entries (registered)
//   level    - queued entries, not counting the frame being shifted (registered)
//   overflow - sticky flag: a strobe arrived while full (registered)
module uart_tx_fifo #(
    parameter int unsigned CLKDIV     = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_BITS-1:0]              d,
    input  logic                              strobe,
    output logic                              tx,
    output logic                              busy,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(CLKDIV);
    localparam int unsigned BW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   tx_d, busy_d, full_d, overflow_d;
    logic [LW-1:0]          level_d;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic                   push_c;
    logic                   load_c;
    logic                   timer_end_c;
    logic [DATA_BITS-1:0]   head_c;
    logic                   head_par_c;

    // FIFO storage; pointers and count carry the valid state, so no reset is needed here
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            full     <= 1'b0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tx       <= tx_d;
            busy     <= busy_d;
            full     <= full_d;
            level    <= level_d;
            overflow <= overflow_d;
        end
    end

    // Next-state, FIFO bookkeeping and registered-output logic
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        tx_d        = tx;
        load_c      = 1'b0;

        push_c      = strobe & ~full;
        timer_end_c = (timer_q == TW'(CLKDIV - 1));
        head_c      = mem[rd_ptr_q];
        // Even parity sends the XOR of the data; odd parity sends its complement
        head_par_c  = (PARITY == 2) ? (^head_c) : (~^head_c);

        // Bit timer wraps at each bit boundary and is parked at zero while idle
        timer_d     = (state_q == S_IDLE || timer_end_c) ? '0 : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                load_c = (level != '0);
            end
            S_START: begin
                if (timer_end_c) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                    tx_d     = shreg_q[0];
                end
            end
            S_DATA: begin
                if (timer_end_c) begin
                    if (bitcnt_q == BW'(DATA_BITS - 1)) begin
                        bitcnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                        shreg_d  = shreg_q >> 1;
                        tx_d     = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (timer_end_c) begin
                    state_d  = S_STOP;
                    bitcnt_d = '0;
                    tx_d     = 1'b1;
                end
            end
            S_STOP: begin
                if (timer_end_c) begin
                    if (bitcnt_q == BW'(STOP_BITS - 1)) begin
                        bitcnt_d = '0;
                        if (level != '0) begin
                            // Chain straight into the next frame without an idle cycle
                            load_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Pop the head into the shifter and begin the start bit
        if (load_c) begin
            state_d  = S_START;
            timer_d  = '0;
            bitcnt_d = '0;
            shreg_d  = head_c;
            par_d    = head_par_c;
            tx_d     = 1'b0;
        end

        wr_ptr_d   = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = load_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level + LW'(push_c) - LW'(load_c);
        full_d     = (level_d == LW'(FIFO_DEPTH));
        busy_d     = (state_d != S_IDLE) || (level_d != '0);
        overflow_d = overflow | (strobe & full);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Three instances cover 8N1 (CLKDIV=4, depth 4), 8E1 (CLKDIV=3) and 7O2 (CLKDIV=2).
// A frame-level reference model predicts every output on every cycle.
// A vector table and directed sequences check the specified corner cases.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       strobe_i [3];
    logic [7:0] d_i [3];
    logic       tx_o [3];
    logic       busy_o [3];
    logic       full_o [3];
    logic       ovf_o [3];
    logic [2:0] lvl0;
    logic [4:0] lvl1;
    logic [3:0] lvl2;
    logic [6:0] d2;

    assign d2 = d_i[2][6:0];

    uart_tx_fifo #(.CLKDIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .d(d_i[0]), .strobe(strobe_i[0]), .tx(tx_o[0]),
        .busy(busy_o[0]), .full(full_o[0]), .level(lvl0), .overflow(ovf_o[0]));

    uart_tx_fifo #(.CLKDIV(3), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .d(d_i[1]), .strobe(strobe_i[1]), .tx(tx_o[1]),
        .busy(busy_o[1]), .full(full_o[1]), .level(lvl1), .overflow(ovf_o[1]));

    uart_tx_fifo #(.CLKDIV(2), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u2 (
        .clk(clk), .rst_n(rst_n), .d(d2), .strobe(strobe_i[2]), .tx(tx_o[2]),
        .busy(busy_o[2]), .full(full_o[2]), .level(lvl2), .overflow(ovf_o[2]));

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    // Per-instance configuration
    function automatic int cdiv_of(input int k);
        case (k) 0: return 4; 1: return 3; default: return 2; endcase
    endfunction
    function automatic int nbits_of(input int k);
        case (k) 0: return 8; 1: return 8; default: return 7; endcase
    endfunction
    function automatic int par_of(input int k);
        case (k) 0: return 0; 1: return 2; default: return 1; endcase
    endfunction
    function automatic int nstop_of(input int k);
        case (k) 0: return 1; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int depth_of(input int k);
        case (k) 0: return 4; 1: return 16; default: return 8; endcase
    endfunction
    function automatic logic [31:0] lvl_of(input int k);
        case (k) 0: return 32'(lvl0); 1: return 32'(lvl1); default: return 32'(lvl2); endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a character queue plus the frame currently on the line,
    // expanded into its list of bits.
    logic [7:0] mq [3][32];
    int         ms [3];
    bit         fb [3][16];
    int         fnb [3];
    int         fcyc [3];
    bit         fact [3];
    bit         movf [3];

    task automatic model_step(input int k, input logic rst, input logic stb, input logic [7:0] din);
        bit         full_pre;
        int         ones;
        int         n;
        logic [7:0] ch;
        if (!rst) begin
            ms[k] = 0; fact[k] = 0; fcyc[k] = 0; movf[k] = 0;
            return;
        end
        full_pre = (ms[k] == depth_of(k));
        if (fact[k]) begin
            fcyc[k]++;
            if (fcyc[k] == fnb[k] * cdiv_of(k)) fact[k] = 0;
        end
        if (!fact[k] && ms[k] > 0) begin
            ch = mq[k][0];
            for (int i = 0; i < 31; i++) mq[k][i] = mq[k][i+1];
            ms[k]--;
            n = 0; ones = 0;
            fb[k][n] = 1'b0; n++;
            for (int i = 0; i < nbits_of(k); i++) begin
                fb[k][n] = ch[i]; n++;
                ones += int'(ch[i]);
            end
            if (par_of(k) == 1) begin fb[k][n] = (ones % 2 == 0); n++; end
            if (par_of(k) == 2) begin fb[k][n] = (ones % 2 == 1); n++; end
            for (int i = 0; i < nstop_of(k); i++) begin fb[k][n] = 1'b1; n++; end
            fnb[k] = n; fcyc[k] = 0; fact[k] = 1;
        end
        if (stb) begin
            if (full_pre) movf[k] = 1;
            else begin mq[k][ms[k]] = din; ms[k]++; end
        end
    endtask

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        for (int k = 0; k < 3; k++) model_step(k, rst_n, strobe_i[k], d_i[k]);
    end

    // Every cycle, compare all outputs of all instances with the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic etx;
            etx = fact[k] ? fb[k][fcyc[k] / cdiv_of(k)] : 1'b1;
            check($sformatf("model u%0d tx", k),    32'(tx_o[k]),   32'(etx));
            check($sformatf("model u%0d busy", k),  32'(busy_o[k]), 32'(fact[k] || ms[k] > 0));
            check($sformatf("model u%0d full", k),  32'(full_o[k]), 32'(ms[k] == depth_of(k)));
            check($sformatf("model u%0d level", k), lvl_of(k),      32'(ms[k]));
            check($sformatf("model u%0d ovf", k),   32'(ovf_o[k]),  32'(movf[k]));
        end
    end

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o[k] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check($sformatf("idle timeout u%0d", k), 32'(busy_o[k]), 32'd0);
    endtask

    function automatic logic n81_bit(input logic [7:0] v, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
        return 1'b1;
    endfunction

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         flen;
        logic [15:0] pat;   // bit i = line level during frame bit i, start bit first
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   e0;
        int   c;
        vec_t v;

        vecs[0] = '{0, 8'h55, 40, 16'h02AA};
        vecs[1] = '{0, 8'h00, 40, 16'h0200};
        vecs[2] = '{1, 8'hA3, 33, 16'h0546};
        vecs[3] = '{1, 8'h01, 33, 16'h0602};
        vecs[4] = '{1, 8'hFF, 33, 16'h05FE};
        vecs[5] = '{2, 8'h41, 22, 16'h0782};
        vecs[6] = '{2, 8'h7F, 22, 16'h06FE};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin strobe_i[k] = 1'b0; d_i[k] = 8'h00; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset u%0d tx", k),    32'(tx_o[k]),   32'd1);
            check($sformatf("reset u%0d busy", k),  32'(busy_o[k]), 32'd0);
            check($sformatf("reset u%0d full", k),  32'(full_o[k]), 32'd0);
            check($sformatf("reset u%0d level", k), lvl_of(k),      32'd0);
            check($sformatf("reset u%0d ovf", k),   32'(ovf_o[k]),  32'd0);
        end
        rst_n = 1'b1;

        // Single frames from idle: exact bit pattern, latency and busy duration
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            wait_idle(v.inst, 500);
            strobe_i[v.inst] = 1'b1;
            d_i[v.inst] = v.data;
            @(negedge clk);
            strobe_i[v.inst] = 1'b0;
            check($sformatf("vec%0d busy after E0", i),  32'(busy_o[v.inst]), 32'd1);
            check($sformatf("vec%0d level after E0", i), lvl_of(v.inst),      32'd1);
            check($sformatf("vec%0d tx after E0", i),    32'(tx_o[v.inst]),   32'd1);
            for (int j = 0; j < v.flen; j++) begin
                @(negedge clk);
                check($sformatf("vec%0d tx cyc%0d", i, j), 32'(tx_o[v.inst]), 32'(v.pat[j / cdiv_of(v.inst)]));
                check($sformatf("vec%0d busy cyc%0d", i, j), 32'(busy_o[v.inst]), 32'd1);
                if (j == 0) check($sformatf("vec%0d level after pop", i), lvl_of(v.inst), 32'd0);
            end
            @(negedge clk);
            check($sformatf("vec%0d busy end", i), 32'(busy_o[v.inst]), 32'd0);
            check($sformatf("vec%0d tx end", i),   32'(tx_o[v.inst]),   32'd1);
        end

        // Depth-4 burst: six strobes, five accepted, five gapless frames
        wait_idle(0, 500);
        e0 = edge_cnt;
        strobe_i[0] = 1'b1;
        d_i[0] = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            d_i[0] = 8'(i + 1);
            if (i == 5) begin
                check("burst full after 5th",  32'(full_o[0]), 32'd1);
                check("burst level after 5th", lvl_of(0),      32'd4);
                check("burst ovf before 6th",  32'(ovf_o[0]),  32'd0);
            end
        end
        @(negedge clk);
        strobe_i[0] = 1'b0;
        check("burst ovf after 6th",   32'(ovf_o[0]),  32'd1);
        check("burst full after 6th",  32'(full_o[0]), 32'd1);
        check("burst level after 6th", lvl_of(0),      32'd4);
        do begin
            @(negedge clk);
            c = edge_cnt - (e0 + 2);
            if (c < 200) begin
                check($sformatf("burst tx c%0d", c), 32'(tx_o[0]), 32'(n81_bit(8'(c / 40 + 1), (c % 40) / 4)));
                check($sformatf("burst busy c%0d", c), 32'(busy_o[0]), 32'd1);
            end
        end while (c < 200);
        check("burst busy end", 32'(busy_o[0]), 32'd0);
        check("burst ovf sticky", 32'(ovf_o[0]), 32'd1);

        // Push and pop on the edge that ends a stop bit
        wait_idle(0, 500);
        e0 = edge_cnt;
        strobe_i[0] = 1'b1; d_i[0] = 8'h11;
        @(negedge clk); d_i[0] = 8'h22;
        @(negedge clk); d_i[0] = 8'h33;
        @(negedge clk); strobe_i[0] = 1'b0;
        while (edge_cnt != e0 + 41) @(negedge clk);
        check("pp level before", lvl_of(0), 32'd2);
        strobe_i[0] = 1'b1; d_i[0] = 8'h44;
        @(negedge clk);
        strobe_i[0] = 1'b0;
        check("pp level kept", lvl_of(0),      32'd2);
        check("pp next start", 32'(tx_o[0]),   32'd0);
        check("pp full",       32'(full_o[0]), 32'd0);
        check("pp busy",       32'(busy_o[0]), 32'd1);
        wait_idle(0, 500);

        // Reset during data bit 3 of 0xFF with three characters queued
        e0 = edge_cnt;
        strobe_i[0] = 1'b1; d_i[0] = 8'hFF;
        @(negedge clk); d_i[0] = 8'hA1;
        @(negedge clk); d_i[0] = 8'hA2;
        @(negedge clk); d_i[0] = 8'hA3;
        @(negedge clk); strobe_i[0] = 1'b0;
        while (edge_cnt != e0 + 18) @(negedge clk);
        check("rst pre level", lvl_of(0),    32'd3);
        check("rst pre tx",    32'(tx_o[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst tx",    32'(tx_o[0]),   32'd1);
        check("rst level", lvl_of(0),      32'd0);
        check("rst busy",  32'(busy_o[0]), 32'd0);
        check("rst ovf",   32'(ovf_o[0]),  32'd0);
        check("rst full",  32'(full_o[0]), 32'd0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check($sformatf("rst quiet tx %0d", i),   32'(tx_o[0]),   32'd1);
            check($sformatf("rst quiet busy %0d", i), 32'(busy_o[0]), 32'd0);
        end

        // Random traffic, alternating light and heavy phases
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if ((i / 500) % 2 == 1) strobe_i[k] = ($urandom_range(0, 2) == 0);
                else                    strobe_i[k] = ($urandom_range(0, 15) == 0);
                d_i[k] = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) strobe_i[k] = 1'b0;
        for (int k = 0; k < 3; k++) wait_idle(k, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
